rf_sequencer: RTL and testbench
===============================

Name: rf_sequencer

Overview:
Command sequencer that sits directly upstream of the 8x8 register file and owns all of its ports. It accepts one register-transfer command at a time over a valid/ready handshake. Each command expands into a fixed sequence of read and write cycles on the register file. Supported operations: load-immediate, move, add, read-out. The ADD datapath is internal.

Parameters:
DATA_W, 8, data width; must match the register file word width
ADDR_W, 3, register address width (2**ADDR_W registers)

Ports:
clk  input  1  rising-edge clock, shared with the register file
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00=LDI, 01=MOV, 10=ADD, 11=RD
cmd_rd  input  ADDR_W  destination register
cmd_rs  input  ADDR_W  source register
cmd_imm  input  DATA_W  immediate value for LDI
rf_I  output  DATA_W  write data to register file
rf_WE  output  1  register file write enable
rf_WA  output  ADDR_W  register file write address
rf_RE  output  1  register file read enable
rf_RA  output  ADDR_W  register file read address
rf_O  input  DATA_W  register file read data; combinational, valid in the same cycle as RE/RA
done  output  1  one-cycle pulse when a command completes
result  output  DATA_W  last value written (LDI/MOV/ADD) or read (RD)
carry  output  1  carry-out of the last ADD

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, cmd_ready=0 while rst_n is low, rf_WE=0, rf_RE=0, rf_WA=0, rf_RA=0, rf_I=0, done=0, result=0, carry=0.
- Register file outputs are Moore outputs decoded from registered state and latched command fields only. They have no combinational path from cmd_*.
- States: IDLE, READ_A, READ_B, WRITE, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at a clock edge, latch op, rd, rs and imm.
  - LDI: latch imm into wdata, go to WRITE.
  - MOV, ADD, RD: go to READ_A.
- READ_A: RE=1, RA=rs; at the clock edge, capture rf_O into tmp.
  - MOV: wdata=rf_O, go to WRITE.
  - ADD: go to READ_B.
  - RD: result<=rf_O, go to DONE.
- READ_B (ADD only): RE=1, RA=rd; at the clock edge, {carry,wdata} <= tmp + rf_O as a (DATA_W+1)-bit sum. Go to WRITE.
- WRITE: WE=1, WA=rd, rf_I=wdata; the register file updates at this edge. result<=wdata, go to DONE.
- DONE: done=1 for exactly one cycle, cmd_ready=0, go to IDLE.
- Outside their active states, RE=0 and WE=0. RA, WA and rf_I hold 0.
- Latency (cycles from accept edge to the done cycle, inclusive): LDI 2, RD 2, MOV 3, ADD 4. cmd_ready returns 1 in the cycle after done.
- Back-to-back throughput: one command per latency+1 cycles.
- cmd_valid while cmd_ready=0 is ignored. The upstream source must hold the command until the handshake.
- carry updates only on ADD and holds through other ops. Sum wraps modulo 2**DATA_W with carry=bit DATA_W.
- ADD with rd==rs: the register value is doubled. MOV with rd==rs: the same value is rewritten. Neither case is special-cased.
- result holds its value until the next completing command.
- Reset mid-command:
  - Asynchronously returns to IDLE and drops WE/RE immediately.
  - Writes already committed at earlier edges remain in the register file.
  - The interrupted command is lost and no done is produced.
- No RE and WE in the same cycle: reads and writes never overlap.

Test Plan:
- Reset then LDI rd=3 imm=0xA5 -> done 2 cycles after accept; WE=1, WA=3, rf_I=0xA5 in WRITE cycle; result=0xA5; readback via RD rs=3 gives result=0xA5.
- LDI r1=0x0F, LDI r2=0x01, ADD rd=1 rs=2 -> RA=2 then RA=1 on consecutive cycles; write r1=0x10, carry=0, done 4 cycles after accept.
- LDI r4=0xF0, LDI r5=0x20, ADD rd=4 rs=5 -> r4=0x10, carry=1; a following MOV rd=6 rs=4 gives r6=0x10 with carry still 1.
- ADD rd=rs=7 with r7=0x80 -> r7=0x00, carry=1; MOV rd=rs=2 leaves r2 unchanged.
- Hold cmd_valid high with changing fields during a busy MOV -> only the handshaken command executes; cmd_ready=0 from accept through done; the next command is accepted in the cycle after done.
- Assert rst_n=0 during READ_B of an ADD -> WE never asserts, no done pulse; destination keeps its old value; outputs at reset values; the next LDI works normally.

Source files
------------

// File: rtl/rf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rf_sequencer
//  Purpose  : Command sequencer that expands LDI/MOV/ADD/RD commands into
//             read and write cycles on an 8x8 register file. It owns every
//             register-file port.
//  Revision : 1.0  initial release
// ============================================================================
module rf_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] rf_I,
    output logic              rf_WE,
    output logic [ADDR_W-1:0] rf_WA,
    output logic              rf_RE,
    output logic [ADDR_W-1:0] rf_RA,
    input  logic [DATA_W-1:0] rf_O,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    localparam logic [1:0] c_OP_LDI = 2'b00;
    localparam logic [1:0] c_OP_MOV = 2'b01;
    localparam logic [1:0] c_OP_ADD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ_A = 3'd1,
        S_READ_B = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_rd;
    logic [ADDR_W-1:0]   r_rs;
    logic [DATA_W-1:0]   r_tmp;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_result;
    logic                r_carry;
    logic [DATA_W:0]     w_sum;

    // Full-width sum keeps the carry-out as the top bit.
    assign w_sum  = {1'b0, r_tmp} + {1'b0, rf_O};
    assign result = r_result;
    assign carry  = r_carry;

    // State register; reset returns to IDLE immediately, dropping RE/WE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and Moore outputs from state plus latched fields.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        rf_RE     = 1'b0;
        rf_RA     = '0;
        rf_WE     = 1'b0;
        rf_WA     = '0;
        rf_I      = '0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Held low while reset is asserted, even though state is IDLE.
                cmd_ready = rst_n;
                if (cmd_valid && rst_n) begin
                    w_next = (cmd_op == c_OP_LDI) ? S_WRITE : S_READ_A;
                end
            end
            S_READ_A: begin
                rf_RE = 1'b1;
                rf_RA = r_rs;
                case (r_op)
                    c_OP_MOV: w_next = S_WRITE;
                    c_OP_ADD: w_next = S_READ_B;
                    default:  w_next = S_DONE;
                endcase
            end
            S_READ_B: begin
                rf_RE  = 1'b1;
                rf_RA  = r_rd;
                w_next = S_WRITE;
            end
            S_WRITE: begin
                rf_WE  = 1'b1;
                rf_WA  = r_rd;
                rf_I   = r_wdata;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command latch and datapath: operand capture, ADD, result and carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_rd     <= '0;
            r_rs     <= '0;
            r_tmp    <= '0;
            r_wdata  <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_rd    <= cmd_rd;
                        r_rs    <= cmd_rs;
                        r_wdata <= cmd_imm;
                    end
                end
                S_READ_A: begin
                    r_tmp <= rf_O;
                    if (r_op == c_OP_MOV) begin
                        r_wdata <= rf_O;
                    end else if (r_op != c_OP_ADD) begin
                        r_result <= rf_O;
                    end
                end
                S_READ_B: begin
                    {r_carry, r_wdata} <= w_sum;
                end
                S_WRITE: begin
                    r_result <= r_wdata;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_sequencer
//  Purpose  : Self-checking bench for rf_sequencer with a behavioural
//             register file and a command-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_MOV = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [ADDR_W-1:0] cmd_rd = '0;
    logic [ADDR_W-1:0] cmd_rs = '0;
    logic [DATA_W-1:0] cmd_imm = '0;
    logic [DATA_W-1:0] rf_I;
    logic              rf_WE;
    logic [ADDR_W-1:0] rf_WA;
    logic              rf_RE;
    logic [ADDR_W-1:0] rf_RA;
    logic [DATA_W-1:0] rf_O;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              carry;

    // Behavioural register file (not cleared by reset).
    logic [DATA_W-1:0] rf_mem [8] = '{default: '0};

    // Reference model state.
    logic [DATA_W-1:0] m_mem [8] = '{default: '0};
    logic [DATA_W-1:0] m_result = '0;
    logic              m_carry = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    // Per-command observations.
    int                cap_lat, cap_wr_cnt, cap_ra_cnt, cap_ra0, cap_ra1;
    logic [ADDR_W-1:0] cap_wa;
    logic [DATA_W-1:0] cap_wi, cap_result;
    logic              cap_carry, cap_overlap, cap_ready_busy, cap_ready_after, cap_done_after;

    rf_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
        .rf_I(rf_I), .rf_WE(rf_WE), .rf_WA(rf_WA),
        .rf_RE(rf_RE), .rf_RA(rf_RA), .rf_O(rf_O),
        .done(done), .result(result), .carry(carry)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Register file write port.
    always @(posedge clk) if (rf_WE) rf_mem[rf_WA] <= rf_I;

    assign rf_O = rf_mem[rf_RA];

    // Command-level reference: what each operation does to the registers.
    task automatic model_apply(input logic [1:0] op, input logic [2:0] rd,
                               input logic [2:0] rs, input logic [7:0] imm);
        logic [8:0] s;
        case (op)
            OP_LDI: begin m_mem[rd] = imm; m_result = imm; end
            OP_MOV: begin m_mem[rd] = m_mem[rs]; m_result = m_mem[rd]; end
            OP_ADD: begin
                s = {1'b0, m_mem[rd]} + {1'b0, m_mem[rs]};
                m_mem[rd] = s[7:0]; m_carry = s[8]; m_result = s[7:0];
            end
            default: m_result = m_mem[rs];
        endcase
    endtask

    function automatic int exp_lat(input logic [1:0] op);
        case (op)
            OP_LDI: return 2;
            OP_MOV: return 3;
            OP_ADD: return 4;
            default: return 2;
        endcase
    endfunction

    // Issue one command at a negedge, then observe the bus until done.
    task automatic send_cmd(input logic [1:0] op, input logic [2:0] rd,
                            input logic [2:0] rs, input logic [7:0] imm);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
        if (!cmd_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_rd = 3'($urandom); cmd_rs = 3'($urandom); cmd_imm = 8'($urandom);
        cap_lat = 0; cap_wr_cnt = 0; cap_ra_cnt = 0; cap_ra0 = -1; cap_ra1 = -1;
        cap_wa = '0; cap_wi = '0; cap_overlap = 1'b0; cap_ready_busy = 1'b0;
        do begin
            @(negedge clk); cap_lat++;
            if (rf_WE) begin cap_wr_cnt++; cap_wa = rf_WA; cap_wi = rf_I; end
            if (rf_RE) begin
                if (cap_ra_cnt == 0) cap_ra0 = int'(rf_RA);
                else if (cap_ra_cnt == 1) cap_ra1 = int'(rf_RA);
                cap_ra_cnt++;
            end
            if (rf_RE && rf_WE) cap_overlap = 1'b1;
            if (cmd_ready) cap_ready_busy = 1'b1;
        end while (!done && cap_lat < 20);
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: done=%b required 1 within 20 cycles", done);
        end
        cap_result = result; cap_carry = carry;
        @(negedge clk);
        cap_ready_after = cmd_ready; cap_done_after = done;
        model_apply(op, rd, rs, imm);
    endtask

    // Reset values while rst_n is low, and ready after release.
    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if ({rf_WE, rf_RE, rf_WA, rf_RA, rf_I, done, result, carry, cmd_ready} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_values: WE=%b RE=%b WA=%h RA=%h I=%h done=%b result=%h carry=%b ready=%b required all 0",
                     rf_WE, rf_RE, rf_WA, rf_RA, rf_I, done, result, carry, cmd_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: ready=%b done=%b required 1/0", cmd_ready, done);
        end
    endtask

    // LDI then RD readback.
    task automatic test_ldi_rd;
        send_cmd(OP_LDI, 3'd3, 3'd0, 8'hA5);
        n_cmp++;
        if (cap_lat !== 2) begin n_fail++; $display("FAIL ldi_latency: got %0d required 2", cap_lat); end
        n_cmp++;
        if (cap_wr_cnt !== 1 || cap_wa !== 3'd3 || cap_wi !== 8'hA5) begin
            n_fail++; $display("FAIL ldi_write: cnt=%0d WA=%h I=%h required 1/3/a5", cap_wr_cnt, cap_wa, cap_wi);
        end
        n_cmp++;
        if (cap_result !== 8'hA5) begin n_fail++; $display("FAIL ldi_result: got %h required a5", cap_result); end
        n_cmp++;
        if ({cap_ready_busy, cap_ready_after, cap_done_after} !== 3'b010) begin
            n_fail++; $display("FAIL ldi_handshake: busy_ready=%b ready_after=%b done_after=%b required 0/1/0",
                               cap_ready_busy, cap_ready_after, cap_done_after);
        end
        send_cmd(OP_RD, 3'd0, 3'd3, 8'h00);
        n_cmp++;
        if (cap_lat !== 2 || cap_result !== 8'hA5) begin
            n_fail++; $display("FAIL rd_readback: lat=%0d result=%h required 2/a5", cap_lat, cap_result);
        end
        n_cmp++;
        if (cap_ra_cnt !== 1 || cap_ra0 !== 3 || cap_wr_cnt !== 0) begin
            n_fail++; $display("FAIL rd_bus: reads=%0d RA=%0d writes=%0d required 1/3/0", cap_ra_cnt, cap_ra0, cap_wr_cnt);
        end
    endtask

    // ADD without carry, checking read order.
    task automatic test_add;
        send_cmd(OP_LDI, 3'd1, 3'd0, 8'h0F);
        send_cmd(OP_LDI, 3'd2, 3'd0, 8'h01);
        send_cmd(OP_ADD, 3'd1, 3'd2, 8'h00);
        n_cmp++;
        if (cap_ra_cnt !== 2 || cap_ra0 !== 2 || cap_ra1 !== 1) begin
            n_fail++; $display("FAIL add_read_order: reads=%0d RA0=%0d RA1=%0d required 2/2/1", cap_ra_cnt, cap_ra0, cap_ra1);
        end
        n_cmp++;
        if (cap_wr_cnt !== 1 || cap_wa !== 3'd1 || cap_wi !== 8'h10 || rf_mem[1] !== 8'h10) begin
            n_fail++; $display("FAIL add_write: cnt=%0d WA=%h I=%h r1=%h required 1/1/10/10", cap_wr_cnt, cap_wa, cap_wi, rf_mem[1]);
        end
        n_cmp++;
        if (cap_carry !== 1'b0 || cap_lat !== 4) begin
            n_fail++; $display("FAIL add_carry_lat: carry=%b lat=%0d required 0/4", cap_carry, cap_lat);
        end
    endtask

    // ADD with carry-out, then MOV keeps carry.
    task automatic test_add_carry;
        send_cmd(OP_LDI, 3'd4, 3'd0, 8'hF0);
        send_cmd(OP_LDI, 3'd5, 3'd0, 8'h20);
        send_cmd(OP_ADD, 3'd4, 3'd5, 8'h00);
        n_cmp++;
        if (rf_mem[4] !== 8'h10 || cap_carry !== 1'b1) begin
            n_fail++; $display("FAIL add_wrap: r4=%h carry=%b required 10/1", rf_mem[4], cap_carry);
        end
        send_cmd(OP_MOV, 3'd6, 3'd4, 8'h00);
        n_cmp++;
        if (rf_mem[6] !== 8'h10 || cap_carry !== 1'b1 || cap_lat !== 3) begin
            n_fail++; $display("FAIL mov_keeps_carry: r6=%h carry=%b lat=%0d required 10/1/3", rf_mem[6], cap_carry, cap_lat);
        end
    endtask

    // rd==rs for ADD (doubling) and MOV (rewrite).
    task automatic test_same_reg;
        send_cmd(OP_LDI, 3'd7, 3'd0, 8'h80);
        send_cmd(OP_ADD, 3'd7, 3'd7, 8'h00);
        n_cmp++;
        if (rf_mem[7] !== 8'h00 || cap_carry !== 1'b1 || cap_result !== 8'h00) begin
            n_fail++; $display("FAIL add_double: r7=%h carry=%b result=%h required 00/1/00", rf_mem[7], cap_carry, cap_result);
        end
        send_cmd(OP_MOV, 3'd2, 3'd2, 8'h00);
        n_cmp++;
        if (rf_mem[2] !== 8'h01 || cap_wr_cnt !== 1 || cap_wi !== 8'h01 || cap_carry !== 1'b1) begin
            n_fail++; $display("FAIL mov_self: r2=%h writes=%0d I=%h carry=%b required 01/1/01/1", rf_mem[2], cap_wr_cnt, cap_wi, cap_carry);
        end
    endtask

    // cmd_valid held high with changing fields while busy.
    task automatic test_busy_hold;
        int  lat;
        logic rdy_bad;
        cmd_valid = 1'b1; cmd_op = OP_MOV; cmd_rd = 3'd5; cmd_rs = 3'd1; cmd_imm = 8'h00;
        @(posedge clk); #1;
        lat = 0; rdy_bad = 1'b0;
        do begin
            cmd_op = OP_LDI; cmd_rd = 3'($urandom); cmd_imm = 8'($urandom);
            @(negedge clk); lat++;
            if (cmd_ready) rdy_bad = 1'b1;
        end while (!done && lat < 20);
        model_apply(OP_MOV, 3'd5, 3'd1, 8'h00);
        n_cmp++;
        if (lat !== 3 || rdy_bad !== 1'b0) begin
            n_fail++; $display("FAIL busy_mov: lat=%0d ready_while_busy=%b required 3/0", lat, rdy_bad);
        end
        cmd_op = OP_LDI; cmd_rd = 3'd0; cmd_imm = 8'h3C;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL busy_ready_after: ready=%b required 1", cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done && lat < 20);
        model_apply(OP_LDI, 3'd0, 3'd0, 8'h3C);
        n_cmp++;
        if (lat !== 2) begin n_fail++; $display("FAIL busy_next_ldi: lat=%0d required 2", lat); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (rf_mem[i] !== m_mem[i]) begin
                n_fail++; $display("FAIL busy_mem r%0d: got %h required %h", i, rf_mem[i], m_mem[i]);
            end
        end
    endtask

    // Reset asserted during READ_B of an ADD.
    task automatic test_reset_mid;
        logic bad;
        logic [7:0] old_r3;
        old_r3 = m_mem[3];
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 3'd3; cmd_rs = 3'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (rf_RE !== 1'b1 || rf_RA !== 3'd3) begin
            n_fail++; $display("FAIL mid_read_b: RE=%b RA=%h required 1/3", rf_RE, rf_RA);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rf_WE, rf_RE, rf_WA, rf_RA, rf_I, done, result, carry, cmd_ready} !== 27'd0) begin
            n_fail++; $display("FAIL mid_reset_values: WE=%b RE=%b WA=%h RA=%h I=%h done=%b result=%h carry=%b ready=%b required all 0",
                               rf_WE, rf_RE, rf_WA, rf_RA, rf_I, done, result, carry, cmd_ready);
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            if (rf_WE || done) bad = 1'b1;
        end
        m_result = '0; m_carry = 1'b0;
        n_cmp++;
        if (bad !== 1'b0 || rf_mem[3] !== old_r3) begin
            n_fail++; $display("FAIL mid_no_commit: we_or_done=%b r3=%h required 0/%h", bad, rf_mem[3], old_r3);
        end
        send_cmd(OP_LDI, 3'd3, 3'd0, 8'h5A);
        n_cmp++;
        if (cap_lat !== 2 || rf_mem[3] !== 8'h5A || cap_result !== 8'h5A || cap_carry !== 1'b0) begin
            n_fail++; $display("FAIL mid_next_ldi: lat=%0d r3=%h result=%h carry=%b required 2/5a/5a/0",
                               cap_lat, rf_mem[3], cap_result, cap_carry);
        end
    endtask

    // Random command stream against the reference model.
    task automatic test_random;
        logic [1:0] op;
        logic [2:0] rd, rs;
        logic [7:0] imm;
        int exp_reads, exp_writes;
        for (int i = 0; i < 160; i++) begin
            op  = (i < 8) ? OP_LDI : 2'($urandom);
            rd  = (i < 8) ? 3'(i) : 3'($urandom);
            rs  = 3'($urandom);
            imm = 8'($urandom);
            repeat ($urandom_range(2, 0)) @(negedge clk);
            send_cmd(op, rd, rs, imm);
            exp_reads  = (op == OP_LDI) ? 0 : (op == OP_ADD) ? 2 : 1;
            exp_writes = (op == OP_RD) ? 0 : 1;
            n_cmp++;
            if (cap_lat !== exp_lat(op) || cap_result !== m_result || cap_carry !== m_carry) begin
                n_fail++; $display("FAIL rand_%0d op=%0d: lat=%0d result=%h carry=%b required %0d/%h/%b",
                                   i, op, cap_lat, cap_result, cap_carry, exp_lat(op), m_result, m_carry);
            end
            n_cmp++;
            if (cap_ra_cnt !== exp_reads || (exp_reads > 0 && cap_ra0 !== int'(rs)) ||
                (exp_reads > 1 && cap_ra1 !== int'(rd))) begin
                n_fail++; $display("FAIL rand_reads_%0d op=%0d: reads=%0d RA0=%0d RA1=%0d required %0d/%0d/%0d",
                                   i, op, cap_ra_cnt, cap_ra0, cap_ra1, exp_reads, rs, rd);
            end
            n_cmp++;
            if (cap_wr_cnt !== exp_writes || (exp_writes == 1 && (cap_wa !== rd || cap_wi !== m_mem[rd]))) begin
                n_fail++; $display("FAIL rand_write_%0d op=%0d: writes=%0d WA=%h I=%h required %0d/%h/%h",
                                   i, op, cap_wr_cnt, cap_wa, cap_wi, exp_writes, rd, m_mem[rd]);
            end
            n_cmp++;
            if ({cap_overlap, cap_ready_busy, cap_ready_after, cap_done_after} !== 4'b0010) begin
                n_fail++; $display("FAIL rand_protocol_%0d: overlap=%b busy_ready=%b ready_after=%b done_after=%b required 0/0/1/0",
                                   i, cap_overlap, cap_ready_busy, cap_ready_after, cap_done_after);
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (rf_mem[i] !== m_mem[i]) begin
                n_fail++; $display("FAIL rand_mem r%0d: got %h required %h", i, rf_mem[i], m_mem[i]);
            end
        end
    endtask

    // Test sequence and summary.
    initial begin
        test_reset;
        test_ldi_rd;
        test_add;
        test_add_carry;
        test_same_reg;
        test_busy_hold;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
